// File: rtl/ct_wb_mailbox.sv
// Wishbone slave mailbox: 32-bit word FIFO fed over Wishbone, drained over valid/ready.
// Define CT_WB_MAILBOX_OVERFLOW_CNT_EN to add the rejected-push counter at word offset 4.
module ct_wb_mailbox #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        irq
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RESP = 1'b1;

   logic          r_state;
   logic [31:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_irq_en;
   logic [CW-1:0] r_thresh;
   logic          r_ack;
   logic          r_err;
   logic [31:0]   r_rdata;
   logic          r_irq;
`ifdef CT_WB_MAILBOX_OVERFLOW_CNT_EN
   logic [15:0]   r_ovf;
`endif

   logic          w_take;
   logic [2:0]    w_off;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_flush;
   logic          w_ctrl_wr;
   logic          w_thresh_wr;
   logic          w_err;
   logic [31:0]   w_rdata;
   logic [31:0]   w_status;
   logic          w_unused;

   assign w_take   = (r_state == ST_IDLE) & wb_cyc_i & wb_stb_i;
   assign w_off    = wb_adr_i[4:2];
   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_pop    = ~w_empty & out_ready;
   assign w_unused = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

   always_comb begin
      w_status           = '0;
      w_status[CW-1:0]   = r_count;
      w_status[16]       = w_empty;
      w_status[17]       = w_full;
   end

   // Decode runs in the accept cycle so reads reflect pre-cycle state.
   always_comb begin
      w_push      = 1'b0;
      w_flush     = 1'b0;
      w_ctrl_wr   = 1'b0;
      w_thresh_wr = 1'b0;
      w_err       = 1'b0;
      w_rdata     = '0;
      if (w_take) begin
         case (w_off)
            3'd0: begin
               if (wb_we_i) begin
                  if ((wb_sel_i != 4'hF) || w_full) w_err = 1'b1;
                  else                              w_push = 1'b1;
               end else if (w_empty) begin
                  w_err = 1'b1;
               end else begin
                  w_rdata = r_mem[r_rptr];
               end
            end
            3'd1: begin
               if (wb_we_i) w_err = 1'b1;
               else         w_rdata = w_status;
            end
            3'd2: begin
               if (wb_we_i) begin
                  w_ctrl_wr = 1'b1;
                  w_flush   = wb_dat_i[1];
               end else begin
                  w_rdata = {31'b0, r_irq_en};
               end
            end
            3'd3: begin
               if (wb_we_i) w_thresh_wr = 1'b1;
               else         w_rdata[CW-1:0] = r_thresh;
            end
`ifdef CT_WB_MAILBOX_OVERFLOW_CNT_EN
            3'd4: begin
               if (!wb_we_i) w_rdata = {16'b0, r_ovf};
            end
`endif
            default: w_err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_irq_en <= 1'b0;
         r_thresh <= '0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_state <= w_take ? ST_RESP : ST_IDLE;
         r_ack   <= w_take & ~w_err;
         r_err   <= w_take & w_err;
         r_rdata <= w_rdata;
         r_irq   <= r_irq_en & (r_thresh != '0) & (r_count >= r_thresh);
         if (w_ctrl_wr)   r_irq_en <= wb_dat_i[0];
         if (w_thresh_wr) r_thresh <= wb_dat_i[CW-1:0];
         // Flush overrides a concurrent pop.
         if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= wb_dat_i;
   end

`ifdef CT_WB_MAILBOX_OVERFLOW_CNT_EN
   logic w_ovf_inc;
   logic w_ovf_clr;
   assign w_ovf_inc = w_take & wb_we_i & (w_off == 3'd0) & w_err;
   assign w_ovf_clr = w_take & wb_we_i & (w_off == 3'd4);

   always_ff @(posedge clk) begin
      if (rst || w_ovf_clr)                     r_ovf <= '0;
      else if (w_ovf_inc && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
   end
`endif

   assign wb_ack_o  = r_ack;
   assign wb_err_o  = r_err;
   assign wb_dat_o  = r_rdata;
   assign out_valid = ~w_empty;
   assign out_data  = w_empty ? '0 : r_mem[r_rptr];
   assign irq       = r_irq;

endmodule

// File: tb/tb_ct_wb_mailbox.sv
// Scoreboard bench for ct_wb_mailbox: a queue-based reference model predicts bus responses,
// stream words, out_valid and irq; a negedge monitor compares them against the DUT.
module tb_ct_wb_mailbox;

   localparam int DEPTH = 16;
   localparam int CW    = 5;
`ifdef CT_WB_MAILBOX_OVERFLOW_CNT_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o, out_data;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
   logic        out_valid, out_ready, irq;

   always #5 clk = ~clk;

   ct_wb_mailbox #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_adr_i  (wb_adr_i),
      .wb_dat_i  (wb_dat_i),
      .wb_sel_i  (wb_sel_i),
      .wb_we_i   (wb_we_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_stb_i  (wb_stb_i),
      .wb_dat_o  (wb_dat_o),
      .wb_ack_o  (wb_ack_o),
      .wb_err_o  (wb_err_o),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .irq       (irq)
   );

   typedef struct {
      bit          err;
      logic [31:0] dat;
      bit          rd;
      int          due;
   } resp_t;

   resp_t       eq[$];
   logic [31:0] sq[$];
   logic [31:0] mq[$];
   bit          m_irq_en;
   int          m_thresh;
   int          m_ovf;
   bit          irq_nxt, vis_irq, vis_valid;
   bit          chk_en = 1'b0;
   int          ncyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
   endtask

   // Predicts what the next clock edge does, given the inputs now driven.
   task automatic step();
      int          sz;
      bit          err, rd, push, flush;
      logic [31:0] d;
      sz        = mq.size();
      vis_valid = (sz != 0);
      vis_irq   = irq_nxt;
      irq_nxt   = m_irq_en && (m_thresh != 0) && (sz >= m_thresh);
      if (rst) begin
         mq.delete();
         m_irq_en = 1'b0;
         m_thresh = 0;
         m_ovf    = 0;
         irq_nxt  = 1'b0;
         return;
      end
      err = 0; rd = 0; push = 0; flush = 0; d = '0;
      if (wb_cyc_i && wb_stb_i) begin
         case (int'(wb_adr_i[4:2]))
            0: if (wb_we_i) begin
                  if (wb_sel_i != 4'hF || sz == DEPTH) begin
                     err = 1;
                     if (OVF && m_ovf < 65535) m_ovf++;
                  end else push = 1;
               end else if (sz == 0) err = 1;
               else begin rd = 1; d = mq[0]; end
            1: if (wb_we_i) err = 1;
               else begin rd = 1; d = 32'(sz); d[16] = (sz == 0); d[17] = (sz == DEPTH); end
            2: if (wb_we_i) begin m_irq_en = wb_dat_i[0]; flush = wb_dat_i[1]; end
               else begin rd = 1; d = 32'(m_irq_en); end
            3: if (wb_we_i) m_thresh = int'(wb_dat_i) & ((1 << CW) - 1);
               else begin rd = 1; d = 32'(m_thresh); end
            4: if (!OVF) err = 1;
               else if (wb_we_i) m_ovf = 0;
               else begin rd = 1; d = 32'(m_ovf); end
            default: err = 1;
         endcase
         eq.push_back('{err, d, rd, ncyc + 1});
      end
      if (out_ready && sz != 0) sq.push_back(mq.pop_front());
      if (push) mq.push_back(wb_dat_i);
      if (flush) mq.delete();
   endtask

   task automatic tick();
      step();
      @(posedge clk);
      #2;
   endtask

   task automatic bus(input bit we, input int off, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] a;
      a        = $urandom();
      a[4:2]   = 3'(off);
      wb_adr_i = a;
      wb_we_i  = we;
      wb_dat_i = dat;
      wb_sel_i = sel;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      tick();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      tick();
   endtask

   always @(negedge clk) begin
      resp_t e;
      if (chk_en) begin
         chk("out_valid", 32'(out_valid), 32'(vis_valid));
         chk("irq", 32'(irq), 32'(vis_irq));
         if (eq.size() != 0 && eq[0].due == ncyc) begin
            e = eq.pop_front();
            chk("ack", 32'(wb_ack_o), 32'(!e.err));
            chk("err", 32'(wb_err_o), 32'(e.err));
            if (e.rd || e.err) chk("rdata", wb_dat_o, e.dat);
         end else begin
            chk("idle_ack_err", {30'b0, wb_ack_o, wb_err_o}, 32'd0);
            chk("idle_dat", wb_dat_o, 32'd0);
         end
         if (out_valid && out_ready) begin
            if (sq.size() == 0) begin
               n_checks++;
               $display("FAIL stream_pop: got handshake with data %h want no word", out_data);
            end else begin
               chk("out_data", out_data, sq.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b1; out_ready = 1'b0;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
      repeat (3) tick();
      rst = 1'b0;
      chk_en = 1'b1;
      bus(0, 1, 0, 4'hF);                          // STATUS after reset

      for (int i = 1; i <= 3; i++) bus(1, 0, 32'hA5A5_0000 + 32'(i), 4'hF);
      bus(0, 1, 0, 4'hF);
      bus(0, 0, 0, 4'hF);
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      tick();

      for (int i = 0; i < 17; i++) bus(1, 0, $urandom(), 4'hF);
      bus(0, 1, 0, 4'hF);
      bus(0, 4, 0, 4'hF);
      bus(1, 2, 32'h2, 4'hF);

      bus(1, 3, 32'd4, 4'hF);
      bus(1, 2, 32'd1, 4'hF);
      for (int i = 0; i < 4; i++) bus(1, 0, $urandom(), 4'hF);
      repeat (2) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      repeat (2) tick();
      bus(1, 2, 32'h2, 4'hF);
      bus(0, 1, 0, 4'hF);

      bus(1, 0, 32'h1234_5678, 4'h3);
      bus(0, 7, 0, 4'hF);
      bus(0, 0, 0, 4'hF);
      bus(1, 3, 32'd0, 4'hF);

      // Full FIFO: push attempt in the same cycle as a pop
      for (int i = 0; i < DEPTH; i++) bus(1, 0, $urandom(), 4'hF);
      wb_adr_i = 32'h0; wb_we_i = 1; wb_dat_i = 32'hDEAD_BEEF; wb_sel_i = 4'hF;
      wb_cyc_i = 1; wb_stb_i = 1; out_ready = 1'b1;
      tick();
      wb_cyc_i = 0; wb_stb_i = 0; out_ready = 1'b0;
      tick();
      bus(0, 1, 0, 4'hF);
      bus(1, 4, 0, 4'hF);
      bus(0, 4, 0, 4'hF);

      // Reset coinciding with an accepted push: no response, everything cleared
      wb_adr_i = 32'h0; wb_we_i = 1; wb_dat_i = 32'h5555_AAAA; wb_sel_i = 4'hF;
      wb_cyc_i = 1; wb_stb_i = 1; rst = 1'b1;
      tick();
      wb_cyc_i = 0; wb_stb_i = 0; rst = 1'b0;
      repeat (2) tick();
      bus(0, 1, 0, 4'hF);

      for (int i = 0; i < 320; i++) begin
         int          off;
         bit          we;
         logic [31:0] d;
         logic [3:0]  s;
         out_ready = ($urandom_range(0, 99) < ((i < 160) ? 10 : 70));
         off = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 7));
         we  = ($urandom_range(0, 3) != 0);
         s   = ($urandom_range(0, 5) == 0) ? 4'($urandom()) : 4'hF;
         d   = $urandom();
         if (off == 2) d[1] = ($urandom_range(0, 7) == 0);
         if (off == 3) d = 32'($urandom_range(0, 20));
         bus(we, off, d, s);
         if ($urandom_range(0, 3) == 0) tick();
      end
      out_ready = 1'b0;
      repeat (3) tick();
      chk_en = 1'b0;
      chk("resp_queue_drained", 32'(eq.size()), 32'd0);
      chk("stream_queue_drained", 32'(sq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
